// File: rtl/brdg_axi_slave_cmd_split_pkg.sv
// Shared definitions for the AXI slave command splitter: field widths, burst encodings,
// FSM state encoding and the size clamp helper.
`ifndef IDW
`define IDW 8
`endif
`ifndef CTXW
`define CTXW 20
`endif

package brdg_axi_slave_cmd_split_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2
   } split_state_e;

   // Oversized AXI sizes are still emitted, just computed as the largest legal beat.
   function automatic logic [2:0] clamp_size(input logic [2:0] size, input int unsigned limit);
      if (32'(size) > limit) begin
         return 3'(limit);
      end
      return size;
   endfunction

endpackage

// File: rtl/brdg_cmd_chunk_calc.sv
// Combinational chunk sizing: aligns the current address to the beat size and limits the
// chunk so it never crosses a 2^BOUNDARY_LOG2-byte boundary.
module brdg_cmd_chunk_calc
   import brdg_axi_slave_cmd_split_pkg::*;
#(
   parameter int BOUNDARY_LOG2 = 7
) (
   input  logic [63:0] addr,
   input  logic [2:0]  size,
   input  logic [8:0]  remaining,
   input  logic [1:0]  burst,
   output logic [8:0]  beats,
   output logic        last,
   output logic [63:0] next_addr
);

   logic [63:0] size_mask;
   logic [63:0] aaddr;
   logic [15:0] to_bnd;

   // size is pre-clamped to <= BOUNDARY_LOG2, so to_bnd is always at least one beat
   always_comb begin
      size_mask = (64'd1 << size) - 64'd1;
      aaddr     = addr & ~size_mask;
      to_bnd    = ((16'd1 << BOUNDARY_LOG2) - 16'(aaddr[BOUNDARY_LOG2-1:0])) >> size;
      if (burst == BURST_FIXED) begin
         beats = 9'd1;
      end else if (to_bnd < 16'(remaining)) begin
         beats = to_bnd[8:0];
      end else begin
         beats = remaining;
      end
      last = (beats == remaining);
      if (burst == BURST_FIXED) begin
         next_addr = addr;
      end else begin
         next_addr = aaddr + (64'(beats) << size);
      end
   end

endmodule

// File: rtl/brdg_axi_slave_cmd_split.sv
// Pops one AXI command from an FWFT FIFO and emits it as boundary-aligned chunks.
// Optional macro BRDG_CMD_SPLIT_CNT_EN adds cmd_cnt/chunk_cnt statistics outputs.
module brdg_axi_slave_cmd_split
   import brdg_axi_slave_cmd_split_pkg::*;
#(
   parameter int BOUNDARY_LOG2 = 7,
   parameter int MAX_SIZE      = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [`IDW-1:0]   cf_id,
   input  logic [63:0]       cf_addr,
   input  logic [7:0]        cf_len,
   input  logic [2:0]        cf_size,
   input  logic [1:0]        cf_burst,
   input  logic [`CTXW-1:0]  cf_user,
   input  logic              cf_empty,
   output logic              cf_rd_en,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [`IDW-1:0]   req_id,
   output logic [63:0]       req_addr,
   output logic [8:0]        req_beats,
   output logic [2:0]        req_size,
   output logic [`CTXW-1:0]  req_user,
   output logic              req_first,
   output logic              req_last,
   output logic              cmd_err
`ifdef BRDG_CMD_SPLIT_CNT_EN
   ,
   output logic [31:0]       cmd_cnt,
   output logic [31:0]       chunk_cnt
`endif
);

   localparam int SIZE_LIMIT = (MAX_SIZE < BOUNDARY_LOG2) ? MAX_SIZE : BOUNDARY_LOG2;

   split_state_e state, state_nxt;
   logic [63:0]  cmd_addr;
   logic [8:0]   remaining;
   logic [1:0]   cmd_burst;
   logic         first;
   logic [2:0]   eff_size;
   logic         cmd_bad;
   logic [8:0]   calc_beats;
   logic         calc_last;
   logic [63:0]  calc_next_addr;

   assign eff_size = clamp_size(req_size, SIZE_LIMIT);
   assign cmd_bad  = (cmd_burst == BURST_WRAP) || (int'(req_size) > MAX_SIZE) ||
                     (int'(req_size) > BOUNDARY_LOG2);

   brdg_cmd_chunk_calc #(
      .BOUNDARY_LOG2(BOUNDARY_LOG2)
   ) u_calc (
      .addr      (cmd_addr),
      .size      (eff_size),
      .remaining (remaining),
      .burst     (cmd_burst),
      .beats     (calc_beats),
      .last      (calc_last),
      .next_addr (calc_next_addr)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The pop is gated by rst_n so nothing leaves the FIFO while reset is held.
   always_comb begin
      state_nxt = state;
      cf_rd_en  = 1'b0;
      req_valid = 1'b0;
      cmd_err   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!cf_empty && rst_n) begin
               cf_rd_en  = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            cmd_err   = first && cmd_bad;
            state_nxt = SEND;
         end
         SEND: begin
            req_valid = 1'b1;
            if (req_ready) begin
               state_nxt = req_last ? IDLE : CALC;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // In SEND the calc inputs are unchanged since CALC, so calc_next_addr matches req_beats.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_addr  <= '0;
         remaining <= '0;
         cmd_burst <= '0;
         first     <= 1'b0;
         req_id    <= '0;
         req_addr  <= '0;
         req_beats <= '0;
         req_size  <= '0;
         req_user  <= '0;
         req_first <= 1'b0;
         req_last  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cf_rd_en) begin
                  cmd_addr  <= cf_addr;
                  remaining <= {1'b0, cf_len} + 9'd1;
                  cmd_burst <= cf_burst;
                  first     <= 1'b1;
                  req_id    <= cf_id;
                  req_size  <= cf_size;
                  req_user  <= cf_user;
               end
            end
            CALC: begin
               req_addr  <= cmd_addr;
               req_beats <= calc_beats;
               req_first <= first;
               req_last  <= calc_last;
            end
            SEND: begin
               if (req_ready) begin
                  remaining <= remaining - req_beats;
                  first     <= 1'b0;
                  cmd_addr  <= calc_next_addr;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BRDG_CMD_SPLIT_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_cnt   <= '0;
         chunk_cnt <= '0;
      end else begin
         if (cf_rd_en) begin
            cmd_cnt <= cmd_cnt + 32'd1;
         end
         if (req_valid && req_ready) begin
            chunk_cnt <= chunk_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
